// File: rtl/operand_stack_spill.sv
// Operand stack: DEPTH resident entries in a circular buffer, spills to / refills from data memory.
// Define STACK_BG_FILL_EN to refill in the background on idle cycles while the buffer is under half full.
module operand_stack_spill #(
  parameter int unsigned DBITS       = 32,
  parameter int unsigned ABITS       = 32,
  parameter int unsigned DEPTH       = 8,
  parameter logic [ABITS-1:0] SPILL_BASE = 32'h0000_1000,
  parameter int unsigned SPILL_WORDS = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DBITS-1:0] push_data,
  output logic [DBITS-1:0] top,
  output logic             top_valid,
  output logic             busy,
  output logic [15:0]      count,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_din,
  input  logic [DBITS-1:0] mem_dout
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned RW = PW + 1;
  localparam logic [RW-1:0] DEPTH_C = RW'(DEPTH);
  localparam logic [RW-1:0] HALF_C  = RW'(DEPTH / 2);
  localparam logic [15:0]   SWORDS_C = 16'(SPILL_WORDS);

  typedef enum logic {IDLE, FILL} state_e;

  logic [DBITS-1:0] stk_q [DEPTH];
  logic [DBITS-1:0] stk_d [DEPTH];
  logic [PW-1:0]    bp_q, bp_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [15:0]      scnt_q, scnt_d;
  state_e           state_q, state_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [PW-1:0]    top_idx, wr_idx, fill_idx;
  logic             do_fill;

  assign top_idx  = bp_q + rcnt_q[PW-1:0] - PW'(1);
  assign wr_idx   = bp_q + rcnt_q[PW-1:0];
  assign fill_idx = bp_q - PW'(1);

`ifdef STACK_BG_FILL_EN
  assign do_fill = (state_q == FILL) ||
                   (!push && !pop && (rcnt_q < HALF_C) && (scnt_q != 16'd0));
`else
  assign do_fill = (state_q == FILL);
`endif

  always_comb begin
    stk_d    = stk_q;
    bp_d     = bp_q;
    rcnt_d   = rcnt_q;
    scnt_d   = scnt_q;
    state_d  = state_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (do_fill) begin
      // Refill slides the bottom pointer down and drops the newest spilled word under it.
      mem_en          = 1'b1;
      mem_addr        = SPILL_BASE + ABITS'(scnt_q) - ABITS'(1);
      stk_d[fill_idx] = mem_dout;
      bp_d            = fill_idx;
      rcnt_d          = rcnt_q + RW'(1);
      scnt_d          = scnt_q - 16'd1;
      state_d         = IDLE;
    end else if (push && (!pop || rcnt_q == '0)) begin
      if (rcnt_q < DEPTH_C) begin
        stk_d[wr_idx] = push_data;
        rcnt_d        = rcnt_q + RW'(1);
      end else if (scnt_q < SWORDS_C) begin
        mem_en      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = SPILL_BASE + ABITS'(scnt_q);
        mem_din     = stk_q[bp_q];
        stk_d[bp_q] = push_data;
        bp_d        = bp_q + PW'(1);
        scnt_d      = scnt_q + 16'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (push) begin
      stk_d[top_idx] = push_data;
    end else if (pop) begin
      if (rcnt_q == '0) begin
        unf_d = 1'b1;
      end else if (rcnt_q == RW'(1) && scnt_q != 16'd0) begin
        rcnt_d  = '0;
        state_d = FILL;
      end else begin
        rcnt_d = rcnt_q - RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bp_q    <= '0;
      rcnt_q  <= '0;
      scnt_q  <= '0;
      state_q <= IDLE;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      stk_q   <= stk_d;
      bp_q    <= bp_d;
      rcnt_q  <= rcnt_d;
      scnt_q  <= scnt_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign top_valid     = (rcnt_q != '0);
  assign top           = top_valid ? stk_q[top_idx] : '0;
  assign busy          = (state_q == FILL);
  assign count         = 16'(rcnt_q) + scnt_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
endmodule

// File: doc/operand_stack_spill.md
# operand_stack_spill

Operand stack for the single-cycle stack CPU. It holds the top DEPTH entries in an on-chip circular register buffer. When the buffer overflows it spills the oldest entry to a reserved region of the data memory, and it refills from that region when the buffer drains. It sits directly upstream of the data memory on a dedicated port: it drives `en`/`we`/`addr`/`din` and consumes the combinational `dout`.

## Interface
- `DBITS`, 32: data word width.
- `ABITS`, 32: memory word-address width; addresses are word indices.
- `DEPTH`, 8: on-chip entries; power of two, at least 4.
- `SPILL_BASE`, 32'h0000_1000: word index of the first spill slot.
- `SPILL_WORDS`, 1024: spill capacity; `DEPTH+SPILL_WORDS` must be below 65536.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `push`  in  1  push `push_data` this cycle.
- `pop`  in  1  pop the top entry this cycle.
- `push_data`  in  DBITS  value to push.
- `top`  out  DBITS  current top of stack; 0 when `top_valid`=0.
- `top_valid`  out  1  top entry is resident.
- `busy`  out  1  block is in FILL; `push`/`pop` are ignored.
- `count`  out  16  total depth (resident + spilled).
- `overflow_err`  out  1  sticky; a push was attempted when full.
- `underflow_err`  out  1  sticky; a pop was attempted when empty.
- `mem_en`, `mem_we`  out  1  data memory enable and write enable.
- `mem_addr`  out  ABITS  data memory word address.
- `mem_din`  out  DBITS  data memory write data.
- `mem_dout`  in  DBITS  data memory read data; combinational and valid in the same cycle as `mem_en`.

## Operation
- State:
  - circular array `buf[DEPTH]`;
  - bottom pointer `bp`;
  - resident count `rcnt` (0..DEPTH);
  - spilled count `scnt` (0..SPILL_WORDS);
  - FSM {IDLE, FILL}.
- Derived values:
  - `count = rcnt + scnt`;
  - top slot is `(bp + rcnt - 1) mod DEPTH`;
  - pointer arithmetic wraps mod DEPTH.
- IDLE, push only, `rcnt < DEPTH`: write `buf[(bp+rcnt) mod DEPTH]`; `rcnt+1`.
- IDLE, push only, `rcnt == DEPTH`, `scnt < SPILL_WORDS` (spill):
  - drive `mem_en=1`, `mem_we=1`, `mem_addr=SPILL_BASE+scnt`, `mem_din=buf[bp]`;
  - `buf[bp] <= push_data`; `bp+1`; `scnt+1`; `rcnt` unchanged.
- IDLE, push only, `count == DEPTH+SPILL_WORDS`: set `overflow_err`; no state change.
- IDLE, pop only, `rcnt > 1`, or `rcnt == 1` with `scnt == 0`: `rcnt-1`.
- IDLE, pop only, `rcnt == 1` with `scnt > 0`: `rcnt <= 0`; go to FILL.
- IDLE, pop only, `count == 0`: set `underflow_err`; no state change.
- IDLE, push and pop together with `rcnt > 0`: replace the top slot with `push_data`; counts unchanged; no memory traffic.
- IDLE, push and pop together with `rcnt == 0`: treated as push only.
- FILL (exactly one cycle):
  - drive `mem_en=1`, `mem_we=0`, `mem_addr=SPILL_BASE+scnt-1`;
  - capture `mem_dout` into `buf[(bp-1) mod DEPTH]`; `bp-1`; `rcnt+1`; `scnt-1`;
  - return to IDLE;
  - `push`/`pop` are ignored with no error flag.
- Memory outputs when not spilling or filling: `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_din=0`.
- Reset (`reset_n=0` at the edge):
  - `rcnt=scnt=bp=0`; FSM=IDLE; both error flags 0;
  - `buf` contents are don't-care;
  - next cycle: `top=0`, `top_valid=0`, `busy=0`, `count=0`, all `mem_*` 0.
  - Reset during FILL aborts the fill; no write is performed and the pending read is discarded.

## Timing
- Push and pop take effect at the rising edge; `top` and `count` reflect the result in the following cycle.
- Spill costs zero stall cycles: the memory write commits at the same edge the push is accepted.
- A pop that empties the buffer while entries are spilled costs one stall cycle:
  - next cycle `busy=1`, `top_valid=0`;
  - the cycle after, `top` is the refilled value and `busy=0`.
- `busy` and `top_valid` are decoded from registered state only; there are no input-to-output combinational paths except `mem_*` from `push`/`pop` in IDLE.

## Configuration
- `STACK_BG_FILL_EN` defined:
  - Trigger: in IDLE, with neither `push` nor `pop` asserted, `rcnt < DEPTH/2` and `scnt > 0`.
  - Action: the block performs a background refill in that cycle, with memory access and state update identical to FILL.
  - `busy` stays 0 and the FSM stays in IDLE.
  - Effect: drained-buffer FILL stalls become rare.
- Not defined: refills occur only through the FILL state.

## Test plan
- DEPTH=4, SPILL_WORDS=4, SPILL_BASE=16, macro undefined unless noted.
- Reset, push 1,2,3,4 -> `top=4`, `count=4`, `mem_we` never asserted.
- Continue pushing 5 then 6 -> spill writes (addr 16, din 1) then (addr 17, din 2); `count=6`; `top=6`.
- Pop four times -> tops 5,4,3 then FILL: `busy=1` one cycle, `mem_addr=17`, read 2; then `top=2`, `count=2`.
- Push 9 and pop together at `count=2` -> `top=9`, `count=2`, no `mem_en`; fill to 8, push again -> `overflow_err=1`, `count=8`; on an empty stack, pop -> `underflow_err=1`.
- Reset asserted during a FILL cycle -> next cycle `count=0`, `busy=0`, `mem_en=0`, both error flags 0.
- With `STACK_BG_FILL_EN`: after the spill scenario, pop to `rcnt=1` then idle -> background read at addr 17 with `busy=0`; `rcnt=2`, `scnt=1`.
